// File: rtl/rd_ctrl_pkg.sv
// Shared types and arithmetic helpers for the packet burst reader.
// Helpers work on 32-bit quantities; callers size-cast the results.
package rd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DATA  = 3'd3,
    ST_DONE  = 3'd4
  } rd_state_e;

  // ceil(num/den); the 33-bit sum keeps num near 2**32 from wrapping
  function automatic logic [31:0] ceil_div(input logic [31:0] num, input logic [31:0] den);
    logic [32:0] sum;
    sum = {1'b0, num} + {1'b0, den} - 33'd1;
    return 32'(sum / {1'b0, den});
  endfunction

  function automatic logic [31:0] min_u(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/rd_burst_addr_gen.sv
// Burst address generator: next burst address, words still to request and the
// size of the next burst. Loaded once per packet, stepped on each accepted read.
module rd_burst_addr_gen
  import rd_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 16,
  parameter int MAX_BURST = 16,
  parameter int BYTES     = 4,
  parameter int BC_W      = $clog2(MAX_BURST) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_begin,
  input  logic [LEN_W-1:0]  i_words,
  input  logic              i_accept,
  output logic [ADDR_W-1:0] o_address,
  output logic [BC_W-1:0]   o_burstcount,
  output logic [LEN_W-1:0]  o_words_left
);

  logic [ADDR_W-1:0] r_address;
  logic [LEN_W-1:0]  r_words_left;
  logic [BC_W-1:0]   r_burstcount;
  logic [LEN_W-1:0]  w_words_next;
  logic [ADDR_W-1:0] w_step;

  assign w_words_next = r_words_left - LEN_W'(r_burstcount);
  assign w_step       = ADDR_W'(r_burstcount) * ADDR_W'(BYTES);

  // burstcount is precomputed so it is already stable when read rises
  always_ff @(posedge clk) begin
    if (reset) begin
      r_address    <= '0;
      r_words_left <= '0;
      r_burstcount <= '0;
    end else if (i_load) begin
      r_address    <= i_begin;
      r_words_left <= i_words;
      r_burstcount <= BC_W'(min_u(32'(i_words), 32'(MAX_BURST)));
    end else if (i_accept) begin
      r_address    <= r_address + w_step;
      r_words_left <= w_words_next;
      r_burstcount <= BC_W'(min_u(32'(w_words_next), 32'(MAX_BURST)));
    end
  end

  assign o_address    = r_address;
  assign o_burstcount = r_burstcount;
  assign o_words_left = r_words_left;

endmodule

// File: rtl/pkt_burst_reader.sv
// Avalon-MM burst read master: fetches [pkt_begin, pkt_end) one burst at a time
// and writes each returned word into the capture FIFO with last/byte-count tags.
module pkt_burst_reader
  import rd_ctrl_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 16,
  localparam int BYTES    = DATA_W / 8,
  localparam int NB_W     = $clog2(BYTES) + 1,
  localparam int BC_W     = $clog2(MAX_BURST) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_pkt_begin,
  input  logic [ADDR_W-1:0] i_pkt_end,
  input  logic              i_almost_full,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [DATA_W-1:0] o_fifo_data,
  output logic              o_fifo_wr,
  output logic              o_fifo_last,
  output logic [NB_W-1:0]   o_fifo_nbytes,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_read,
  output logic [BC_W-1:0]   o_burstcount,
  input  logic [DATA_W-1:0] i_readdata,
  input  logic              i_readdatavalid,
  input  logic              i_waitrequest,
  output rd_state_e         o_dbg_state
);

  // Avalon handshake: a read is accepted on a rising edge where read=1 and
  // waitrequest=0; until then read, address and burstcount hold their values.

  rd_state_e         r_state;
  logic [ADDR_W-1:0] r_begin;
  logic [ADDR_W-1:0] r_end;
  logic [NB_W-1:0]   r_tail;
  logic [BC_W-1:0]   r_beats;

  logic [ADDR_W-1:0] w_len;
  logic [LEN_W-1:0]  w_len_lo;
  logic [LEN_W-1:0]  w_words;
  logic [LEN_W-1:0]  w_words_left;
  logic              w_err;
  logic              w_load;
  logic              w_accept;
  logic              w_burst_end;
  logic              w_final_beat;
  logic [NB_W-1:0]   w_nbytes;

  assign w_len    = r_end - r_begin;
  assign w_len_lo = w_len[LEN_W-1:0];
  assign w_words  = LEN_W'(ceil_div(32'(w_len_lo), 32'(BYTES)));
  assign w_err    = (r_end < r_begin)
                  || ((r_begin & ADDR_W'(BYTES - 1)) != '0)
                  || ((w_len >> LEN_W) != '0);

  assign w_load       = (r_state == ST_LOAD) && !w_err && (w_len != '0);
  assign w_accept     = (r_state == ST_ISSUE) && o_read && !i_waitrequest;
  assign w_burst_end  = i_readdatavalid && (r_beats == BC_W'(1));
  assign w_final_beat = w_burst_end && (w_words_left == '0);
  assign w_nbytes     = (w_final_beat && (r_tail != '0)) ? r_tail : NB_W'(BYTES);

  rd_burst_addr_gen #(
    .ADDR_W   (ADDR_W),
    .LEN_W    (LEN_W),
    .MAX_BURST(MAX_BURST),
    .BYTES    (BYTES),
    .BC_W     (BC_W)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_begin     (r_begin),
    .i_words     (w_words),
    .i_accept    (w_accept),
    .o_address   (o_address),
    .o_burstcount(o_burstcount),
    .o_words_left(w_words_left)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_begin       <= '0;
      r_end         <= '0;
      r_tail        <= '0;
      r_beats       <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
      o_read        <= 1'b0;
      o_fifo_wr     <= 1'b0;
      o_fifo_last   <= 1'b0;
      o_fifo_data   <= '0;
      o_fifo_nbytes <= '0;
    end else begin
      o_fifo_wr   <= 1'b0;
      o_fifo_last <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_begin <= i_pkt_begin;
            r_end   <= i_pkt_end;
            o_busy  <= 1'b1;
            o_err   <= 1'b0;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_tail <= NB_W'(w_len & ADDR_W'(BYTES - 1));
          if (w_err) begin
            o_err   <= 1'b1;
            o_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_len == '0) begin
            o_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            o_read  <= !i_almost_full;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (o_read) begin
            if (!i_waitrequest) begin
              o_read  <= 1'b0;
              r_beats <= o_burstcount;
              r_state <= ST_DATA;
            end
          end else if (!i_almost_full) begin
            o_read <= 1'b1;
          end
        end
        ST_DATA: begin
          // beats==0 only after the final burst: this cycle carries the last
          // fifo_wr, so done lands one cycle behind it
          if (r_beats == '0) begin
            o_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (i_readdatavalid) begin
            o_fifo_wr     <= 1'b1;
            o_fifo_data   <= i_readdata;
            o_fifo_last   <= w_final_beat;
            o_fifo_nbytes <= w_nbytes;
            r_beats       <= r_beats - BC_W'(1);
            if (w_burst_end && !w_final_beat) begin
              o_read  <= !i_almost_full;
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pkt_burst_reader.sv
// Bench for pkt_burst_reader: Avalon memory responder, FIFO-side scoreboard and
// one task per scenario, run in sequence from a single initial block.
module tb_pkt_burst_reader;
  import rd_ctrl_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int NB_W   = 3;
  localparam int BC_W   = 5;
  localparam int EW     = DATA_W + NB_W + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_start;
  logic [ADDR_W-1:0] i_pkt_begin;
  logic [ADDR_W-1:0] i_pkt_end;
  logic              i_almost_full;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  logic [DATA_W-1:0] o_fifo_data;
  logic              o_fifo_wr;
  logic              o_fifo_last;
  logic [NB_W-1:0]   o_fifo_nbytes;
  logic [ADDR_W-1:0] o_address;
  logic              o_read;
  logic [BC_W-1:0]   o_burstcount;
  logic [DATA_W-1:0] i_readdata;
  logic              i_readdatavalid;
  logic              i_waitrequest;
  rd_state_e         dbg_state;

  always #5 clk = ~clk;

  pkt_burst_reader dut (
    .clk            (clk),
    .reset          (reset),
    .i_start        (i_start),
    .i_pkt_begin    (i_pkt_begin),
    .i_pkt_end      (i_pkt_end),
    .i_almost_full  (i_almost_full),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err),
    .o_fifo_data    (o_fifo_data),
    .o_fifo_wr      (o_fifo_wr),
    .o_fifo_last    (o_fifo_last),
    .o_fifo_nbytes  (o_fifo_nbytes),
    .o_address      (o_address),
    .o_read         (o_read),
    .o_burstcount   (o_burstcount),
    .i_readdata     (i_readdata),
    .i_readdatavalid(i_readdatavalid),
    .i_waitrequest  (i_waitrequest),
    .o_dbg_state    (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0]     exp_q[$];
  logic [DATA_W-1:0] resp_q[$];
  logic [ADDR_W-1:0] acc_addr_q[$];
  logic [BC_W-1:0]   acc_bc_q[$];
  int                read_hi;
  int                wr_cnt;
  int                done_cnt;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5a00_00a5;
  endfunction

  // Negedge observer: records accepted bursts (queuing their beats for the
  // responder) and checks every FIFO write against the expected queue.
  task automatic monitor_cycle();
    logic [EW-1:0] exp_w;
    logic [EW-1:0] got_w;
    if (o_read === 1'b1) read_hi++;
    if (o_done === 1'b1) done_cnt++;
    if (o_read === 1'b1 && i_waitrequest === 1'b0) begin
      acc_addr_q.push_back(o_address);
      acc_bc_q.push_back(o_burstcount);
      for (int i = 0; i < int'(o_burstcount); i++)
        resp_q.push_back(data_of(o_address + 32'(i) * 32'd4));
    end
    if (o_fifo_wr === 1'b1) begin
      wr_cnt++;
      checks++;
      got_w = {o_fifo_last, o_fifo_nbytes, o_fifo_data};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL fifo_word: unexpected write got %h, none expected", got_w);
      end else begin
        exp_w = exp_q.pop_front();
        if (got_w !== exp_w) begin
          failures++;
          $display("FAIL fifo_word: got {last,nb,data}=%h want %h", got_w, exp_w);
        end
      end
    end
  endtask

  task automatic responder_cycle();
    if (resp_q.size() > 0) begin
      i_readdatavalid = 1'b1;
      i_readdata      = resp_q.pop_front();
    end else begin
      i_readdatavalid = 1'b0;
    end
  endtask

  // Push the expected FIFO words, clear per-packet stats and pulse start.
  task automatic start_packet(input logic [31:0] b, input logic [31:0] e);
    logic [31:0] len;
    logic        last;
    logic [2:0]  nb;
    int          nw;
    len = e - b;
    if (!(e < b) && b[1:0] == 2'b00 && len < 32'h1_0000 && len != 32'd0) begin
      nw = int'((len + 32'd3) / 32'd4);
      for (int i = 0; i < nw; i++) begin
        last = (i == nw - 1);
        nb   = (last && len[1:0] != 2'b00) ? {1'b0, len[1:0]} : 3'd4;
        exp_q.push_back({last, nb, data_of(b + 32'(i) * 32'd4)});
      end
    end
    acc_addr_q.delete();
    acc_bc_q.delete();
    read_hi  = 0;
    wr_cnt   = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    i_start     = 1'b1;
    i_pkt_begin = b;
    i_pkt_end   = e;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // k counts negedges from the cycle after start; bounded wait for done.
  task automatic wait_done(output int k, output logic err);
    bit found;
    found = 0;
    k     = 0;
    err   = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(negedge clk);
      k++;
      if (o_done === 1'b1) begin
        found = 1;
        err   = o_err;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL done_timeout: no done after %0d cycles, want done", k);
    end
    @(negedge clk);
    checks++;
    if ({o_busy, o_done, done_cnt} !== {1'b0, 1'b0, 32'd1}) begin
      failures++;
      $display("FAIL done_pulse: got busy=%b done=%b pulses=%0d want 0 0 1", o_busy, o_done, done_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_busy, o_done, o_err, o_fifo_wr, o_fifo_last, o_read, o_fifo_data,
         o_fifo_nbytes, o_address, o_burstcount} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: outputs not all 0 (busy=%b read=%b addr=%h)", o_busy, o_read, o_address);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_busy, o_done, o_read, o_fifo_wr} !== 4'b0000 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL idle_after_reset: got busy=%b done=%b read=%b wr=%b state=%0d want 0 0 0 0 IDLE",
               o_busy, o_done, o_read, o_fifo_wr, dbg_state);
    end
  endtask

  task automatic test_single_burst();
    int   k;
    logic err;
    start_packet(32'h100, 32'h140);
    @(negedge clk);
    checks++;
    if ({o_busy, o_read} !== 2'b10) begin
      failures++;
      $display("FAIL load_cycle: got busy,read=%b want 10", {o_busy, o_read});
    end
    @(negedge clk);
    checks++;
    if ({o_read, o_address, o_burstcount} !== {1'b1, 32'h100, 5'd16}) begin
      failures++;
      $display("FAIL first_read: got read=%b addr=%h bc=%0d want 1 100 16", o_read, o_address, o_burstcount);
    end
    wait_done(k, err);
    checks++;
    if (acc_addr_q.size() != 1 || acc_addr_q[0] !== 32'h100 || acc_bc_q[0] !== 5'd16) begin
      failures++;
      $display("FAIL single_bursts: got %0d bursts first addr=%h bc=%0d want 1 100 16",
               acc_addr_q.size(), acc_addr_q[0], acc_bc_q[0]);
    end
    checks++;
    if (wr_cnt != 16 || exp_q.size() != 0 || err !== 1'b0) begin
      failures++;
      $display("FAIL single_writes: got wr=%0d left=%0d err=%b want 16 0 0", wr_cnt, exp_q.size(), err);
    end
  endtask

  task automatic test_two_bursts();
    int   k;
    logic err;
    start_packet(32'h200, 32'h25A);
    wait_done(k, err);
    checks++;
    if (acc_addr_q.size() != 2 || acc_addr_q[0] !== 32'h200 || acc_bc_q[0] !== 5'd16
        || acc_addr_q[1] !== 32'h240 || acc_bc_q[1] !== 5'd7) begin
      failures++;
      $display("FAIL two_bursts: got n=%0d %h/%0d %h/%0d want 2 200/16 240/7", acc_addr_q.size(),
               acc_addr_q[0], acc_bc_q[0], acc_addr_q[1], acc_bc_q[1]);
    end
    checks++;
    if (wr_cnt != 23 || exp_q.size() != 0 || err !== 1'b0) begin
      failures++;
      $display("FAIL two_writes: got wr=%0d left=%0d err=%b want 23 0 0", wr_cnt, exp_q.size(), err);
    end
  endtask

  task automatic test_almost_full();
    int   k;
    int   bad;
    logic err;
    bit   seen;
    start_packet(32'h200, 32'h25A);
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (acc_addr_q.size() == 1) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL af_first_burst: got %0d bursts want 1", acc_addr_q.size());
    end
    @(posedge clk); #1;
    i_almost_full = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_read !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL af_hold: got %0d read cycles while almost_full want 0", bad);
    end
    @(posedge clk); #1;
    i_almost_full = 1'b0;
    @(negedge clk);
    checks++;
    if (o_read !== 1'b0) begin
      failures++;
      $display("FAIL af_release_cycle: got read=%b want 0", o_read);
    end
    @(negedge clk);
    checks++;
    if ({o_read, o_address, o_burstcount} !== {1'b1, 32'h240, 5'd7}) begin
      failures++;
      $display("FAIL af_resume: got read=%b addr=%h bc=%0d want 1 240 7", o_read, o_address, o_burstcount);
    end
    wait_done(k, err);
    checks++;
    if (acc_addr_q.size() != 2 || wr_cnt != 23 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL af_totals: got bursts=%0d wr=%0d left=%0d want 2 23 0", acc_addr_q.size(), wr_cnt, exp_q.size());
    end
  endtask

  task automatic test_waitrequest();
    int   k;
    logic err;
    bit   seen;
    i_waitrequest = 1'b1;
    start_packet(32'h100, 32'h140);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (o_read === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL wr_read_seen: got read=%b want 1", o_read);
    end
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if ({o_read, o_address, o_burstcount} !== {1'b1, 32'h100, 5'd16}) begin
        failures++;
        $display("FAIL wr_hold%0d: got read=%b addr=%h bc=%0d want 1 100 16", c, o_read, o_address, o_burstcount);
      end
      if (c == 2) begin
        @(posedge clk); #1;
        i_waitrequest = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (o_read !== 1'b0) begin
      failures++;
      $display("FAIL wr_drop: got read=%b want 0", o_read);
    end
    wait_done(k, err);
    checks++;
    if (acc_addr_q.size() != 1 || read_hi != 4 || wr_cnt != 16 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL wr_totals: got bursts=%0d read_cycles=%0d wr=%0d want 1 4 16",
               acc_addr_q.size(), read_hi, wr_cnt);
    end
  endtask

  task automatic test_bad_requests();
    logic [31:0] bv[3];
    logic [31:0] ev[3];
    logic        ex[3];
    int          k;
    logic        err;
    bv[0] = 32'h140; ev[0] = 32'h100; ex[0] = 1'b1;
    bv[1] = 32'h101; ev[1] = 32'h140; ex[1] = 1'b1;
    bv[2] = 32'h180; ev[2] = 32'h180; ex[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_packet(bv[i], ev[i]);
      wait_done(k, err);
      checks++;
      if (k > 3 || err !== ex[i]) begin
        failures++;
        $display("FAIL bad_req%0d: got done after %0d cycles err=%b want <=3 err=%b", i, k, err, ex[i]);
      end
      checks++;
      if (read_hi != 0 || wr_cnt != 0 || o_err !== ex[i]) begin
        failures++;
        $display("FAIL bad_req%0d_quiet: got reads=%0d wr=%0d err_hold=%b want 0 0 %b",
                 i, read_hi, wr_cnt, o_err, ex[i]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int   k;
    int   w0;
    int   d0;
    logic err;
    bit   seen;
    start_packet(32'h100, 32'h140);
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (wr_cnt >= 10) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL rst_progress: got wr=%0d want 10", wr_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    w0 = wr_cnt;
    d0 = done_cnt;
    @(negedge clk);
    checks++;
    if ({o_busy, o_done, o_err, o_read, o_fifo_wr, o_address, o_burstcount} !== '0 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL rst_outputs: got busy=%b read=%b wr=%b addr=%h state=%0d want all 0 IDLE",
               o_busy, o_read, o_fifo_wr, o_address, dbg_state);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (wr_cnt != w0 || done_cnt != d0 || resp_q.size() != 0) begin
      failures++;
      $display("FAIL rst_late_beats: got wr=%0d done=%0d pending=%0d want %0d %0d 0",
               wr_cnt, done_cnt, resp_q.size(), w0, d0);
    end
    start_packet(32'h300, 32'h340);
    wait_done(k, err);
    checks++;
    if (acc_addr_q.size() != 1 || acc_addr_q[0] !== 32'h300 || wr_cnt != 16 || exp_q.size() != 0 || err !== 1'b0) begin
      failures++;
      $display("FAIL rst_restart: got bursts=%0d addr=%h wr=%0d err=%b want 1 300 16 0",
               acc_addr_q.size(), acc_addr_q[0], wr_cnt, err);
    end
  endtask

  initial begin
    reset           = 1'b1;
    i_start         = 1'b0;
    i_pkt_begin     = '0;
    i_pkt_end       = '0;
    i_almost_full   = 1'b0;
    i_readdata      = '0;
    i_readdatavalid = 1'b0;
    i_waitrequest   = 1'b0;
    read_hi         = 0;
    wr_cnt          = 0;
    done_cnt        = 0;
    fork
      forever begin
        @(negedge clk);
        monitor_cycle();
      end
      forever begin
        @(posedge clk); #1;
        responder_cycle();
      end
    join_none
    test_reset();
    test_single_burst();
    test_two_bursts();
    test_almost_full();
    test_waitrequest();
    test_bad_requests();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
